dm_responder: RTL

//  Memory-side responder for the multi-cycle RISC-V core's load/store port.

---
 rtl/dm_responder_pkg.sv | 24 ++
 rtl/dm_responder_if.sv | 23 ++
 rtl/dm_lane_align.sv | 33 +++
 rtl/dm_responder.sv | 113 +++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: shared funct3 width codes, FSM states and default MMIO address
package dm_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] DEF_MMIO_ADDR = 32'hFFFF_FF00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Loads accept every defined width; stores have no unsigned variants.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        return (f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                (!we && (f3 == F3_BU || f3 == F3_HU)));
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// dm_responder_if: CPU load/store request and response handshake bundle
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_lane_align.sv
// dm_lane_align: byte-lane store merge, load extract/extend and alignment check
module dm_lane_align
    import dm_responder_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);
    logic [4:0]  w_sh;
    logic [31:0] w_lane;
    logic [31:0] w_mask;
    logic        w_is_b;
    logic        w_is_h;
    logic        w_sext;

    // Shift the addressed lane to bit 0 for loads and mask the stored lane into the old word.
    always_comb begin
        w_sh       = {i_addr_lo, 3'b000};
        w_lane     = i_old_word >> w_sh;
        w_is_b     = (i_funct3 == F3_B) || (i_funct3 == F3_BU);
        w_is_h     = (i_funct3 == F3_H) || (i_funct3 == F3_HU);
        w_sext     = !i_funct3[2];
        w_mask     = w_is_b ? 32'h0000_00FF : w_is_h ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        o_misalign = (w_is_h && i_addr_lo[0]) || ((i_funct3 == F3_W) && (i_addr_lo != 2'b00));
        o_wword    = (i_old_word & ~(w_mask << w_sh)) | ((i_wdata & w_mask) << w_sh);
        o_rdata    = w_is_b ? {{24{w_sext & w_lane[7]}}, w_lane[7:0]} :
                     w_is_h ? {{16{w_sext & w_lane[15]}}, w_lane[15:0]} : i_old_word;
    end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: memory-side load/store responder with wait states and one MMIO display word
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int          ADDR_W      = 6,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_ADDR   = DEF_MMIO_ADDR
) (
    input  logic           clk,
    input  logic           rst,
    dm_responder_if.slave  bus,
    output logic [31:0]    o_led_data
);
    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_ready;
    logic                r_we;
    logic [2:0]          r_f3;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [31:0]         r_led;
    logic [31:0]         r_mem [2**ADDR_W];

    logic                w_accept;
    logic                w_go_resp;
    logic                w_mmio;
    logic                w_err;
    logic                w_misalign;
    logic [ADDR_W-1:0]   w_idx;
    logic [31:0]         w_old;
    logic [31:0]         w_wword;
    logic [31:0]         w_rdata;

    assign w_accept   = (r_state == ST_IDLE) && r_ready && bus.req_valid;
    assign w_go_resp  = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_idx      = r_addr[ADDR_W+1:2];
    assign w_mmio     = (r_addr[31:2] == MMIO_ADDR[31:2]);
    assign w_old      = w_mmio ? r_led : r_mem[w_idx];
    assign w_err      = w_misalign || !f3_legal(r_f3, r_we) ||
                        (!w_mmio && (r_addr[31:ADDR_W+2] != '0));

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign o_led_data     = r_led;

    dm_lane_align u_align (
        .i_funct3   (r_f3),
        .i_addr_lo  (r_addr[1:0]),
        .i_old_word (w_old),
        .i_wdata    (r_wdata),
        .o_wword    (w_wword),
        .o_rdata    (w_rdata),
        .o_misalign (w_misalign)
    );

    // FSM state register; async reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next state: a request always passes through WAIT, which holds WAIT_CYCLES+1 cycles.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
            ST_RESP: if (bus.resp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latch, wait counter, response registers, LED and the one-cycle-late ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_led   <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_f3    <= bus.req_funct3;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_cnt   <= 4'(WAIT_CYCLES);
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_go_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_we) ? 32'd0 : w_rdata;
                if (!w_err && r_we && w_mmio) r_led <= w_wword;
            end
            r_ready <= (r_state == ST_IDLE) && (w_next == ST_IDLE);
        end
    end

    // Word array is never cleared; a store lands once, on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (w_go_resp && !w_err && r_we && !w_mmio) r_mem[w_idx] <= w_wword;
    end
endmodule
